// File: rtl/AXI_package.sv
// Command and status encodings shared between the job loader and AXI_top.
package AXI_package;

    localparam logic [7:0] CMD_NOP         = 8'h00;
    localparam logic [7:0] CMD_WRITE       = 8'h01;
    localparam logic [7:0] CMD_START       = 8'h02;

    localparam logic [7:0] STATUS_RUNNING  = 8'h01;
    localparam logic [7:0] STATUS_ACCEPTED = 8'h02;
    localparam logic [7:0] STATUS_REJECTED = 8'h03;

endpackage

// File: rtl/regex_job_loader_if.sv
// Job stream (half-word input) and result handshake of the regex job loader.
interface regex_job_loader_if;

    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;

    logic        res_valid;
    logic        res_ready;
    logic        res_accept;
    logic        res_error;

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, res_accept, res_error
    );

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, res_accept, res_error
    );

endinterface

// File: rtl/regex_job_loader.sv
// Loads a regex code image and a string into the matcher memory through the
// AXI_top register window, starts the matcher and reports its verdict.
module regex_job_loader
    import AXI_package::*;
#(
    parameter int REG_WIDTH     = 32,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    regex_job_loader_if.slave    job,
    output logic [REG_WIDTH-1:0] address_register,
    output logic [REG_WIDTH-1:0] data_in_register,
    output logic [REG_WIDTH-1:0] cmd_register,
    output logic [REG_WIDTH-1:0] start_cc_pointer_register,
    input  logic [REG_WIDTH-1:0] status_register,
    output logic                 busy
);

    localparam int TMO_W = $clog2(START_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

    localparam logic [REG_WIDTH-1:0] CMD_NOP_W   = REG_WIDTH'(CMD_NOP);
    localparam logic [REG_WIDTH-1:0] CMD_WRITE_W = REG_WIDTH'(CMD_WRITE);
    localparam logic [REG_WIDTH-1:0] CMD_START_W = REG_WIDTH'(CMD_START);
    localparam logic [REG_WIDTH-1:0] ST_RUN_W    = REG_WIDTH'(STATUS_RUNNING);
    localparam logic [REG_WIDTH-1:0] ST_ACC_W    = REG_WIDTH'(STATUS_ACCEPTED);
    localparam logic [REG_WIDTH-1:0] ST_REJ_W    = REG_WIDTH'(STATUS_REJECTED);

    typedef enum logic [3:0] {
        IDLE,
        LD_CODE,
        LD_STR,
        WR_ADDR,
        WR_CMD,
        WR_NOP,
        WR_TERM,
        START,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [REG_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0] str_base;
    logic [31:0]          word_buf;
    logic                 half_cnt;
    logic                 word_last;
    logic                 in_str;
    logic                 in_term;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 acc_q;
    logic                 err_q;

    logic                 ld_phase;
    logic                 hw_accept;
    logic                 word_done;
    logic                 running;
    logic [REG_WIDTH-1:0] word_ext;

    assign ld_phase  = (state == LD_CODE) || (state == LD_STR);
    assign hw_accept = ld_phase && job.s_valid;
    assign word_done = hw_accept && (half_cnt || job.s_last);
    assign running   = (status_register == ST_RUN_W);
    assign word_ext  = REG_WIDTH'(word_buf);

    assign job.s_ready    = ld_phase;
    assign job.res_valid  = (state == DONE);
    assign job.res_accept = acc_q;
    assign job.res_error  = err_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address and data are held across the whole three-cycle write so AXI_top
    // may latch them on either side of the CMD_WRITE pulse.
    always_comb begin
        state_next                = state;
        cmd_register              = CMD_NOP_W;
        address_register          = '0;
        data_in_register          = '0;
        start_cc_pointer_register = '0;
        case (state)
            IDLE: begin
                if (job.s_valid) begin
                    state_next = LD_CODE;
                end
            end
            LD_CODE, LD_STR: begin
                if (word_done) begin
                    state_next = WR_ADDR;
                end
            end
            WR_ADDR: begin
                address_register = addr;
                data_in_register = word_ext;
                state_next       = WR_CMD;
            end
            WR_CMD: begin
                address_register = addr;
                data_in_register = word_ext;
                cmd_register     = CMD_WRITE_W;
                state_next       = WR_NOP;
            end
            WR_NOP: begin
                address_register = addr;
                data_in_register = word_ext;
                if (in_term) begin
                    state_next = START;
                end else if (!word_last) begin
                    state_next = in_str ? LD_STR : LD_CODE;
                end else if (!in_str) begin
                    state_next = LD_STR;
                end else begin
                    state_next = WR_TERM;
                end
            end
            WR_TERM: begin
                state_next = WR_ADDR;
            end
            START: begin
                start_cc_pointer_register = str_base;
                cmd_register              = CMD_START_W;
                if (running) begin
                    state_next = RUN;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = DONE;
                end
            end
            RUN: begin
                if (!running) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (job.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Half-word packing: the first half lands low and clears the upper half,
    // so a word closed early by s_last is already zero-padded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_buf  <= '0;
            half_cnt  <= 1'b0;
            word_last <= 1'b0;
        end else if (state == IDLE) begin
            word_buf  <= '0;
            half_cnt  <= 1'b0;
            word_last <= 1'b0;
        end else if (hw_accept) begin
            if (!half_cnt) begin
                word_buf <= {16'h0000, job.s_data};
                half_cnt <= !job.s_last;
            end else begin
                word_buf[31:16] <= job.s_data;
                half_cnt        <= 1'b0;
            end
            word_last <= job.s_last;
        end else if (state == WR_TERM) begin
            word_buf <= '0;
        end
    end

    // The word after the code image is a guard slot: it is skipped, never
    // written, and the string starts one word further on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            str_base <= '0;
            in_str   <= 1'b0;
            in_term  <= 1'b0;
        end else if (state == IDLE) begin
            addr     <= '0;
            str_base <= '0;
            in_str   <= 1'b0;
            in_term  <= 1'b0;
        end else if (state == WR_NOP) begin
            if (!in_term && word_last && !in_str) begin
                addr     <= addr + REG_WIDTH'(4);
                str_base <= addr + REG_WIDTH'(4);
                in_str   <= 1'b1;
            end else begin
                addr <= addr + REG_WIDTH'(2);
                if (!in_term && word_last && in_str) begin
                    in_term <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == START) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // The verdict is captured once on leaving START/RUN and then held
    // unchanged for the whole DONE handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc_q <= 1'b0;
                    err_q <= 1'b0;
                end
                START: begin
                    if (!running && tmo_cnt == TMO_LAST) begin
                        acc_q <= 1'b0;
                        err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!running) begin
                        acc_q <= (status_register == ST_ACC_W);
                        err_q <= (status_register != ST_ACC_W) &&
                                 (status_register != ST_REJ_W);
                    end
                end
                DONE: begin
                    if (job.res_ready) begin
                        acc_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regex_job_loader.sv
// Randomized scoreboard bench for regex_job_loader with a behavioural AXI_top
// status model and a monitor that checks writes, start pulses and verdicts.
module tb_regex_job_loader;
    import AXI_package::*;

    localparam int RW  = 32;
    localparam int TMO = 8;
    localparam logic [RW-1:0] ST_NONE = 32'h0000_0000;
    localparam logic [RW-1:0] ST_BAD  = 32'h0000_00A5;

    typedef enum int {M_ACCEPT, M_REJECT, M_BAD, M_NEVER} mode_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        acc;
        logic        err;
        logic [31:0] ptr;
        int          start_cycles;
        int          latency;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] address_register;
    logic [RW-1:0] data_in_register;
    logic [RW-1:0] cmd_register;
    logic [RW-1:0] start_cc_pointer_register;
    logic [RW-1:0] status_register;
    logic          busy;

    regex_job_loader_if job_if();

    regex_job_loader #(.REG_WIDTH(RW), .START_TIMEOUT(TMO)) dut (
        .clk                       (clk),
        .reset                     (rst_n),
        .job                       (job_if),
        .address_register          (address_register),
        .data_in_register          (data_in_register),
        .cmd_register              (cmd_register),
        .start_cc_pointer_register (start_cc_pointer_register),
        .status_register           (status_register),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    wr_t   exp_wr[$];
    res_t  exp_res[$];
    int    total_writes = 0;
    bit    abort = 0;
    bit    drv_done = 0;
    logic [15:0] rst_code[$];

    mode_t mode = M_ACCEPT;
    int    run_delay = 3;
    int    run_len = 2;
    bit    active;
    int    tick;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic bail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s wait bound expired", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // AXI_top model: counts cycles from the first CMD_START cycle, reports
    // RUNNING from run_delay on, then the final verdict after run_len more cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            tick   <= 0;
        end else if (job_if.res_valid && job_if.res_ready) begin
            active <= 1'b0;
            tick   <= 0;
        end else if (active) begin
            tick <= tick + 1;
        end else if (cmd_register == RW'(CMD_START)) begin
            active <= 1'b1;
            tick   <= 1;
        end
    end

    always_comb begin
        status_register = ST_NONE;
        if (active && mode != M_NEVER && tick >= run_delay) begin
            if (tick < run_delay + 1 + run_len) begin
                status_register = RW'(STATUS_RUNNING);
            end else begin
                case (mode)
                    M_ACCEPT: status_register = RW'(STATUS_ACCEPTED);
                    M_REJECT: status_register = RW'(STATUS_REJECTED);
                    default:  status_register = ST_BAD;
                endcase
            end
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard queues.
    initial begin
        int  sc_run = 0;
        int  lat = 0;
        bit  lat_on = 0;
        bit  idle_chk = 0;
        bit  nop_chk = 0;
        wr_t last_wr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sc_run = 0; lat_on = 0; idle_chk = 0; nop_chk = 0;
            end else begin
                if (nop_chk) begin
                    check_output("nop_addr_stable", address_register, last_wr.addr);
                    check_output("nop_data_stable", data_in_register, last_wr.data);
                    nop_chk = 0;
                end
                if (cmd_register == RW'(CMD_WRITE)) begin
                    total_writes++;
                    if (exp_wr.size() == 0) begin
                        check_output("unexpected_write_addr", address_register, 32'hFFFF_FFFF);
                    end else begin
                        last_wr = exp_wr.pop_front();
                        check_output("write_addr", address_register, last_wr.addr);
                        check_output("write_data", data_in_register, last_wr.data);
                        nop_chk = 1;
                    end
                end
                if (cmd_register == RW'(CMD_START)) begin
                    if (sc_run == 0) begin
                        if (exp_res.size() == 0)
                            check_output("unexpected_start", start_cc_pointer_register, 32'hFFFF_FFFF);
                        else
                            check_output("start_ptr", start_cc_pointer_register, exp_res[0].ptr);
                        lat_on = 1;
                        lat = 0;
                    end
                    sc_run++;
                end else if (sc_run > 0) begin
                    if (exp_res.size() > 0)
                        check_output("start_cycles", 32'(sc_run), 32'(exp_res[0].start_cycles));
                    check_output("cmd_after_start", cmd_register, RW'(CMD_NOP));
                    sc_run = 0;
                end
                if (lat_on) begin
                    if (job_if.res_valid) begin
                        if (exp_res.size() > 0)
                            check_output("result_latency", 32'(lat), 32'(exp_res[0].latency));
                        lat_on = 0;
                    end else begin
                        lat++;
                    end
                end
                if (idle_chk) begin
                    check_output("idle_busy", {31'd0, busy}, 32'd0);
                    check_output("idle_res_valid", {31'd0, job_if.res_valid}, 32'd0);
                    idle_chk = 0;
                end
                if (job_if.res_valid) begin
                    if (exp_res.size() == 0) begin
                        check_output("unexpected_result", {31'd0, job_if.res_valid}, 32'd0);
                    end else begin
                        check_output("res_accept", {31'd0, job_if.res_accept}, {31'd0, exp_res[0].acc});
                        check_output("res_error", {31'd0, job_if.res_error}, {31'd0, exp_res[0].err});
                        if (job_if.res_ready) begin
                            void'(exp_res.pop_front());
                            idle_chk = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic rand_hw(input int n, output logic [15:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(16'($urandom));
    endtask

    // Reference packing: consecutive pairs form {second,first}; an odd tail
    // half-word forms a word on its own with a zero upper half.
    task automatic pack_words(input logic [15:0] q[$], inout logic [31:0] a);
        for (int i = 0; i < q.size(); i += 2) begin
            wr_t w;
            logic [15:0] hi;
            hi = (i + 1 < q.size()) ? q[i+1] : 16'h0000;
            w.addr = a;
            w.data = {hi, q[i]};
            exp_wr.push_back(w);
            a = a + 32'd2;
        end
    endtask

    task automatic build_expect(input logic [15:0] code[$], input logic [15:0] str[$], output logic [31:0] ptr);
        logic [31:0] a;
        wr_t term;
        a = 32'd0;
        pack_words(code, a);
        a = a + 32'd2;
        ptr = a;
        pack_words(str, a);
        term.addr = a;
        term.data = 32'd0;
        exp_wr.push_back(term);
    endtask

    task automatic send_phase(input logic [15:0] hw[$], input int gap_pct);
        for (int i = 0; i < hw.size() && !abort; i++) begin
            bit accepted;
            int guard;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                job_if.s_valid = 1'b0;
                job_if.s_data  = 16'($urandom);
                job_if.s_last  = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            job_if.s_valid = 1'b1;
            job_if.s_data  = hw[i];
            job_if.s_last  = (i == hw.size() - 1);
            accepted = 0;
            guard = 0;
            while (!accepted && !abort) begin
                @(negedge clk);
                accepted = job_if.s_ready && rst_n;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 200) bail("s_ready_timeout");
            end
        end
        job_if.s_valid = 1'b0;
        job_if.s_last  = 1'b0;
    endtask

    task automatic wait_result(input int hold_low);
        int guard = 0;
        while (!job_if.res_valid) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) bail("res_valid_timeout");
        end
        if (hold_low > 0) begin
            repeat (hold_low) @(posedge clk);
            #1;
            job_if.res_ready = 1'b1;
        end
        guard = 0;
        while (busy) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 50) bail("idle_timeout");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] code[$], input logic [15:0] str[$],
                                  input mode_t m, input int d, input int r,
                                  input int hold_low, input int gap);
        res_t e;
        logic [31:0] ptr;
        mode      = m;
        run_delay = d;
        run_len   = r;
        build_expect(code, str, ptr);
        e.ptr = ptr;
        e.acc = (m == M_ACCEPT);
        e.err = (m == M_BAD) || (m == M_NEVER);
        e.start_cycles = (m == M_NEVER) ? TMO : d + 1;
        e.latency      = (m == M_NEVER) ? TMO : d + 2 + r;
        exp_res.push_back(e);
        job_if.res_ready = (hold_low == 0);
        send_phase(code, gap);
        send_phase(str, gap);
        wait_result(hold_low);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_cmd"}, cmd_register, RW'(CMD_NOP));
        check_output({tag, "_addr"}, address_register, 32'd0);
        check_output({tag, "_data"}, data_in_register, 32'd0);
        check_output({tag, "_ptr"}, start_cc_pointer_register, 32'd0);
        check_output({tag, "_s_ready"}, {31'd0, job_if.s_ready}, 32'd0);
        check_output({tag, "_res_valid"}, {31'd0, job_if.res_valid}, 32'd0);
        check_output({tag, "_res_accept"}, {31'd0, job_if.res_accept}, 32'd0);
        check_output({tag, "_res_error"}, {31'd0, job_if.res_error}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_test();
        logic [15:0] str[$];
        logic [31:0] ptr;
        int base;
        int guard;
        rand_hw(6, rst_code);
        rand_hw(2, str);
        mode = M_ACCEPT;
        build_expect(rst_code, str, ptr);
        base = total_writes;
        abort = 0;
        drv_done = 0;
        job_if.res_ready = 1'b1;
        fork
            begin
                send_phase(rst_code, 0);
                drv_done = 1;
            end
        join_none
        guard = 0;
        while (total_writes < base + 2) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 200) bail("second_write_timeout");
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("midjob_reset");
        abort = 1;
        guard = 0;
        while (!drv_done) begin
            @(posedge clk);
            guard++;
            if (guard > 20) bail("driver_abort_timeout");
        end
        exp_wr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        bail("watchdog");
    end

    initial begin
        logic [15:0] code[$];
        logic [15:0] str[$];
        job_if.s_valid   = 1'b0;
        job_if.s_data    = 16'h0000;
        job_if.s_last    = 1'b0;
        job_if.res_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed job, accept");
        code = {16'h0161, 16'h0262, 16'h0000};
        str  = {16'h6261};
        apply_stimulus(code, str, M_ACCEPT, 3, 2, 0, 0);

        $display("[TB] reject with res_ready held low");
        rand_hw(5, code);
        rand_hw(3, str);
        apply_stimulus(code, str, M_REJECT, 2, 1, 10, 0);

        $display("[TB] start timeout");
        rand_hw(2, code);
        rand_hw(2, str);
        apply_stimulus(code, str, M_NEVER, 1, 0, 0, 0);

        $display("[TB] reset during second code write");
        reset_test();

        $display("[TB] random jobs with valid gaps");
        for (int j = 0; j < 10; j++) begin
            mode_t m;
            rand_hw($urandom_range(1, 7), code);
            rand_hw($urandom_range(1, 5), str);
            m = mode_t'($urandom_range(0, 3));
            apply_stimulus(code, str, m, $urandom_range(1, 5), $urandom_range(0, 4),
                           $urandom_range(0, 3), 40);
        end

        check_output("writes_left", 32'(exp_wr.size()), 32'd0);
        check_output("results_left", 32'(exp_res.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regex_job_loader.md
REGEX_JOB_LOADER -- requirements
Module: regex_job_loader

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, width of all register-side ports.
REQ-002 SHALL have parameter START_TIMEOUT, default 64, maximum number of cycles to wait for STATUS_RUNNING after CMD_START.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk in 1 (system clock); reset in 1 (asynchronous, active-low).
REQ-004 SHALL have these job input ports: s_valid in 1, half-word valid; s_ready out 1, half-word accepted when s_valid&&s_ready; s_data in 16, code instruction {type,data} or two string bytes {hi,lo}; s_last in 1, last half-word of the current phase.
REQ-005 SHALL have these register-side ports to AXI_top: address_register out REG_WIDTH; data_in_register out REG_WIDTH; cmd_register out REG_WIDTH; start_cc_pointer_register out REG_WIDTH; status_register in REG_WIDTH.
REQ-006 SHALL have these result ports: res_valid out 1; res_ready in 1; res_accept out 1, 1=ACCEPTED; res_error out 1, 1=timeout or bad status; busy out 1, high in every state except IDLE.
REQ-007 SHALL take CMD_* and STATUS_* encodings from AXI_package.

Function
REQ-008 SHALL implement the states IDLE, LD_CODE, LD_STR, WR_ADDR, WR_CMD, WR_NOP, WR_TERM, START, RUN and DONE.
REQ-009 SHALL, in IDLE, move to LD_CODE on s_valid with s_ready=0 and no input consumed; code_addr=0.
REQ-010 SHALL assert s_ready only in LD_CODE and LD_STR while no complete word is pending.
REQ-011 SHALL pack a word from the first accepted half-word into [15:0] and the second into [31:16]; a word SHALL be complete after two half-words, or after one if it carried s_last, in which case [31:16]=0.
REQ-012 SHALL write a complete word in three cycles: WR_ADDR drives address_register=addr and data_in_register=word; WR_CMD drives cmd_register=CMD_WRITE; WR_NOP drives cmd_register=CMD_NOP and adds 2 to addr.
REQ-013 SHALL leave address_register and data_in_register stable from WR_ADDR through WR_NOP.
REQ-014 SHALL, after WR_NOP, return to the loading phase if the word did not contain s_last.
REQ-015 SHALL, after the last code word, set str_base=addr+2 (one guard word is skipped and never written) and enter LD_STR.
REQ-016 SHALL, after the last string word, enter WR_TERM, write one all-zero word at the next addr with the same 3-cycle sequence, then enter START.
REQ-017 SHALL, in START, drive start_cc_pointer_register=str_base and cmd_register=CMD_START and clear the timeout counter; it SHALL drive cmd_register=CMD_NOP and enter RUN in the cycle after status_register==STATUS_RUNNING is sampled.
REQ-018 SHALL, if STATUS_RUNNING is not seen within START_TIMEOUT cycles of START, drive CMD_NOP and enter DONE with res_error=1 and res_accept=0.
REQ-019 SHALL, in RUN, hold while status==STATUS_RUNNING and then enter DONE: STATUS_ACCEPTED gives res_accept=1, res_error=0; STATUS_REJECTED gives res_accept=0, res_error=0; any other value gives res_error=1, res_accept=0.
REQ-020 SHALL, in DONE, hold res_valid=1 with stable res_accept and res_error until res_ready; on res_valid&&res_ready it SHALL enter IDLE the next cycle, and it SHALL complete the handshake in a single cycle if res_ready is already high.
REQ-021 SHALL wrap addr at 2^REG_WIDTH modulo without an error flag; no address overflow checking is performed.
REQ-022 SHALL ignore s_valid outside LD_CODE and LD_STR, and s_data SHALL NOT be consumed there.

Reset
REQ-023 SHALL, while reset=0, immediately set state=IDLE, s_ready=0, cmd_register=CMD_NOP, address_register=0, data_in_register=0, start_cc_pointer_register=0, res_valid=0, res_accept=0, res_error=0, busy=0, and clear addr, str_base, the packing buffer and the timeout counter.
REQ-024 SHALL, on a mid-job reset, abandon the job and issue no further command; the partial memory contents are undefined and the next job SHALL rewrite from address 0.

Verification
REQ-025 SHALL be verified with code 0x0161,0x0262,0x0000 (s_last on the third) and string 0x6261 (last): writes {0x0262,0x0161}@0, {0x0000,0x0000}@2, {0x0000,0x6261}@6, 0@8; start_cc_pointer=6.
REQ-026 SHALL be verified with a model that gives RUNNING 3 cycles after START and then ACCEPTED: res_valid=1, res_accept=1, res_error=0, and CMD_START held for exactly the cycles until RUNNING is sampled.
REQ-027 SHALL be verified with the model reporting REJECTED while res_ready is held low for 10 cycles: res_valid stays 1 with stable outputs, and IDLE is reached one cycle after res_ready.
REQ-028 SHALL be verified with a model that never reports RUNNING and START_TIMEOUT=8: res_error=1 eight cycles after START entry, cmd_register=CMD_NOP.
REQ-029 SHALL be verified with reset asserted during WR_CMD of the second code word: outputs reach reset values with no clock edge, and a following job writes from address 0 again.
REQ-030 SHALL be verified with s_valid toggled randomly during loading: the write order and packing are identical to a back-to-back stream and no half-word is lost or duplicated.
